hdmi_tmds_decoder: RTL and testbench
====================================

HDMI_TMDS_DECODER -- requirements
Module: hdmi_tmds_decoder

Interface
REQ-001 Parameter: LGDIM, 16, width of every timing-measurement counter and output.
REQ-002 Parameter: LGERR, 16, width of the saturating error counter.
REQ-003 Port: i_pix_clk  input  1  pixel clock, the only clock.
REQ-004 Port: i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: i_r, i_g, i_b  input  10 each  bit-aligned TMDS words from the sync stage, one per pixel clock.
REQ-006 Port: o_r, o_g, o_b  output  8 each  decoded pixel; 0 when o_de=0.
REQ-007 Port: o_de  output  1  data enable (video period).
REQ-008 Port: o_hsync, o_vsync  output  1 each  sync bits from the blue-channel control token.
REQ-009 Port: o_htotal, o_hactive, o_vtotal, o_vactive  output  LGDIM each  measured timing (clocks per line, DE clocks per line, lines per frame, DE lines per frame).
REQ-010 Port: o_timing_valid  output  1  measurements stable.
REQ-011 Port: o_err_count  output  LGERR  saturating count of channel-disagreement clocks.

Function
REQ-012 Control tokens: 10'h354 -> C=00, 10'h0AB -> C=01, 10'h154 -> C=10, 10'h2AB -> C=11; C[0]=hsync, C[1]=vsync, taken from the blue channel only.
REQ-013 Data words: q = d[9] ? ~d[7:0] : d[7:0]; out[0]=q[0]; out[i] = d[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]) for i=1..7.
REQ-014 Per channel, a word is "control" iff it matches one of the four tokens; o_de = 1 iff blue is not control.
REQ-015 Decode pipeline latency: exactly 2 clocks from input word to o_r/o_g/o_b/o_de/o_hsync/o_vsync, all aligned.
REQ-016 While o_de=0, o_hsync/o_vsync hold the last token's C bits; while o_de=1, both hold their last control-period value.
REQ-017 Error: any clock in which the three channels do not agree on control-vs-data increments o_err_count by 1, saturating at all-ones; no wrap.
REQ-018 Line measurement: the line counter restarts on each DE rising edge; on that edge, the previous count latches to a staged htotal and the DE-high count to a staged hactive.
REQ-019 Frame measurement: on each vsync rising edge, the lines seen since the previous edge latch to a staged vtotal and the lines containing DE to a staged vactive.
REQ-020 Outputs o_htotal/o_hactive/o_vtotal/o_vactive update only at a vsync rising edge, from the staged values.
REQ-021 o_timing_valid = 1 iff two consecutive frames produced identical staged quadruples and no counter saturated; it clears at the first differing frame edge.
REQ-022 Counter overflow: any measurement counter reaching all-ones saturates and marks the frame invalid; o_timing_valid drops at the next vsync edge.
REQ-023 The first DE edge and the first vsync edge after reset latch nothing (no prior reference); measurements begin at the second edge.
REQ-024 A DE rising edge and a vsync rising edge in the same clock: line bookkeeping first, then the frame latch includes that line.

Reset
REQ-025 i_reset_n low asynchronously clears all pipeline registers, counters, staged values, outputs, o_err_count and o_timing_valid to 0.
REQ-026 Reset mid-frame discards partial measurements; REQ-023 applies again after release.

Structure
REQ-027 TMDS token constants (four control codes) and the C-bit field positions live in the shared hdmi package.
REQ-028 One sub-module, tmds_chan_decode (10b in, 8b data + control flag + 2b C out, registered), instantiated three times.

Verification
REQ-029 Blue=10'h0AB, r/g=10'h354 -> after 2 clocks: de=0, hsync=1, vsync=0, err unchanged.
REQ-030 All 256 values encoded by a reference TMDS encoder, both DC-balance branches -> decoded output equals the original byte, 2-clock latency.
REQ-031 Blue data, green control token for 5 clocks -> o_err_count increments by exactly 5; preloaded at all-ones less 2 -> saturates at all-ones.
REQ-032 Three 640x480 frames (800x525 total) -> after the third vsync edge: htotal=800, hactive=640, vtotal=525, vactive=480, timing_valid=1.
REQ-033 Fourth frame with htotal=801 -> timing_valid=0 at its vsync edge; valid again after two matching 801 frames.
REQ-034 Reset asserted mid-line 100 of a frame -> all outputs 0 immediately; after release, valid only after 3 vsync edges.

Source files
------------

// File: rtl/hdmi_tmds_decoder_pkg.sv
// Shared TMDS definitions: the four control tokens, the C-bit positions, and a
// pure function that turns one 10-bit TMDS word into data byte / control info.
package hdmi_tmds_decoder_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'h354;
    localparam logic [9:0] TOKEN_C01 = 10'h0AB;
    localparam logic [9:0] TOKEN_C10 = 10'h154;
    localparam logic [9:0] TOKEN_C11 = 10'h2AB;

    localparam int C_HSYNC_BIT = 0;
    localparam int C_VSYNC_BIT = 1;

    typedef struct packed {
        logic [7:0] data;
        logic       is_ctrl;
        logic [1:0] c;
    } chan_word_t;

    function automatic chan_word_t tmds_decode_word(input logic [9:0] w);
        chan_word_t r;
        logic [7:0] q;
        r = '0;
        q = w[9] ? ~w[7:0] : w[7:0];
        case (w)
            TOKEN_C00: begin r.is_ctrl = 1'b1; r.c = 2'b00; end
            TOKEN_C01: begin r.is_ctrl = 1'b1; r.c = 2'b01; end
            TOKEN_C10: begin r.is_ctrl = 1'b1; r.c = 2'b10; end
            TOKEN_C11: begin r.is_ctrl = 1'b1; r.c = 2'b11; end
            default: begin
                // Undo the XOR/XNOR transition-minimising chain; d[8] picks which.
                r.data[0] = q[0];
                for (int i = 1; i < 8; i++) begin
                    r.data[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hdmi_tmds_decoder_chan_decode.sv
// One TMDS channel: decodes a 10-bit word into data byte, control flag and
// C bits, registered (first of the two pipeline stages).
module tmds_chan_decode
    import hdmi_tmds_decoder_pkg::*;
(
    input  logic       i_pix_clk,
    input  logic       i_reset_n,
    input  logic [9:0] i_word,
    output logic [7:0] o_data,
    output logic       o_ctrl,
    output logic [1:0] o_c
);

    chan_word_t word_d;
    chan_word_t word_q;

    always_comb begin
        // NOTE: combinational outputs are fully assigned on every path, so no latch is inferred.
        word_d = tmds_decode_word(i_word);
    end

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!i_reset_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign o_data = word_q.data;
    assign o_ctrl = word_q.is_ctrl;
    assign o_c    = word_q.c;

endmodule

// File: rtl/hdmi_tmds_decoder.sv
// HDMI/DVI TMDS receiver back end: three channel decoders, aligned pixel/sync
// outputs, channel-disagreement error counter and video timing measurement.
module hdmi_tmds_decoder
    import hdmi_tmds_decoder_pkg::*;
#(
    parameter int LGDIM = 16,
    parameter int LGERR = 16
) (
    input  logic             i_pix_clk,
    input  logic             i_reset_n,
    input  logic [9:0]       i_r,
    input  logic [9:0]       i_g,
    input  logic [9:0]       i_b,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [LGDIM-1:0] o_htotal,
    output logic [LGDIM-1:0] o_hactive,
    output logic [LGDIM-1:0] o_vtotal,
    output logic [LGDIM-1:0] o_vactive,
    output logic             o_timing_valid,
    output logic [LGERR-1:0] o_err_count
);

    typedef struct packed {
        logic [LGDIM-1:0] htotal;
        logic [LGDIM-1:0] hactive;
        logic [LGDIM-1:0] vtotal;
        logic [LGDIM-1:0] vactive;
    } timing_t;

    function automatic logic [LGDIM-1:0] sat_inc(input logic [LGDIM-1:0] v);
        return (v == '1) ? v : v + LGDIM'(1);
    endfunction

    logic [7:0] r_data, g_data, b_data;
    logic       r_ctrl, g_ctrl, b_ctrl;
    logic [1:0] r_c, g_c, b_c;

    tmds_chan_decode u_dec_r (.i_pix_clk(i_pix_clk), .i_reset_n(i_reset_n), .i_word(i_r),
                              .o_data(r_data), .o_ctrl(r_ctrl), .o_c(r_c));
    tmds_chan_decode u_dec_g (.i_pix_clk(i_pix_clk), .i_reset_n(i_reset_n), .i_word(i_g),
                              .o_data(g_data), .o_ctrl(g_ctrl), .o_c(g_c));
    tmds_chan_decode u_dec_b (.i_pix_clk(i_pix_clk), .i_reset_n(i_reset_n), .i_word(i_b),
                              .o_data(b_data), .o_ctrl(b_ctrl), .o_c(b_c));

    // Sync bits come from blue only; red/green C bits are intentionally dropped.
    logic unused_c;
    assign unused_c = ^{r_c, g_c};

    logic [7:0]       pix_r_d, pix_r_q, pix_g_d, pix_g_q, pix_b_d, pix_b_q;
    logic             de_d, de_q, hsync_d, hsync_q, vsync_d, vsync_q;
    logic [LGERR-1:0] err_d, err_q;
    logic             de_prev_d, de_prev_q, hs_prev_d, hs_prev_q, vs_prev_d, vs_prev_q;
    logic [LGDIM-1:0] hcount_d, hcount_q, hact_d, hact_q;
    logic [LGDIM-1:0] vlines_d, vlines_q, vact_d, vact_q;
    logic [LGDIM-1:0] stg_htotal_d, stg_htotal_q, stg_hactive_d, stg_hactive_q;
    logic             line_seen_d, line_seen_q, frame_seen_d, frame_seen_q;
    logic             have_prev_d, have_prev_q, bad_d, bad_q, valid_d, valid_q;
    timing_t          prev_timing_d, prev_timing_q, out_timing_d, out_timing_q;

    logic             de_rise, hs_rise, vs_rise, sat_now, bad_all;
    logic [LGDIM-1:0] vlines_nx, vact_nx;
    timing_t          cur_timing;

    assign de_rise = de_q & ~de_prev_q;
    assign hs_rise = hsync_q & ~hs_prev_q;
    assign vs_rise = vsync_q & ~vs_prev_q;
    assign sat_now = (hcount_q == '1) || (hact_q == '1) || (vlines_q == '1) || (vact_q == '1);

    // Second pipeline stage and the disagreement counter.
    always_comb begin
        de_d    = ~b_ctrl;
        pix_r_d = b_ctrl ? 8'h00 : r_data;
        pix_g_d = b_ctrl ? 8'h00 : g_data;
        pix_b_d = b_ctrl ? 8'h00 : b_data;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (b_ctrl) begin
            hsync_d = b_c[C_HSYNC_BIT];
            vsync_d = b_c[C_VSYNC_BIT];
        end
        err_d = err_q;
        if (((r_ctrl != b_ctrl) || (g_ctrl != b_ctrl)) && (err_q != '1)) begin
            err_d = err_q + LGERR'(1);
        end
        de_prev_d = de_q;
        hs_prev_d = hsync_q;
        vs_prev_d = vsync_q;
    end

    // Timing measurement on the aligned output stream; line work precedes the frame latch.
    always_comb begin
        hcount_d      = sat_inc(hcount_q);
        hact_d        = de_q ? sat_inc(hact_q) : hact_q;
        stg_htotal_d  = stg_htotal_q;
        stg_hactive_d = stg_hactive_q;
        line_seen_d   = line_seen_q;
        vlines_nx     = hs_rise ? sat_inc(vlines_q) : vlines_q;
        vact_nx       = de_rise ? sat_inc(vact_q) : vact_q;
        if (de_rise) begin
            if (line_seen_q) begin
                stg_htotal_d  = hcount_q;
                stg_hactive_d = hact_q;
            end
            line_seen_d = 1'b1;
            hcount_d    = LGDIM'(1);
            hact_d      = LGDIM'(1);
        end

        bad_all    = bad_q | sat_now;
        cur_timing = '{htotal: stg_htotal_d, hactive: stg_hactive_d,
                       vtotal: vlines_nx, vactive: vact_nx};

        vlines_d      = vlines_nx;
        vact_d        = vact_nx;
        bad_d         = bad_all;
        frame_seen_d  = frame_seen_q;
        have_prev_d   = have_prev_q;
        prev_timing_d = prev_timing_q;
        out_timing_d  = out_timing_q;
        valid_d       = valid_q;
        if (vs_rise) begin
            vlines_d     = '0;
            vact_d       = '0;
            bad_d        = 1'b0;
            frame_seen_d = 1'b1;
            if (frame_seen_q) begin
                out_timing_d  = cur_timing;
                prev_timing_d = cur_timing;
                valid_d       = have_prev_q && (cur_timing == prev_timing_q) && !bad_all;
                have_prev_d   = !bad_all;
            end
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            err_q         <= '0;
            de_prev_q     <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hcount_q      <= '0;
            hact_q        <= '0;
            vlines_q      <= '0;
            vact_q        <= '0;
            stg_htotal_q  <= '0;
            stg_hactive_q <= '0;
            line_seen_q   <= 1'b0;
            frame_seen_q  <= 1'b0;
            have_prev_q   <= 1'b0;
            bad_q         <= 1'b0;
            valid_q       <= 1'b0;
            prev_timing_q <= '0;
            out_timing_q  <= '0;
        end else begin
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            err_q         <= err_d;
            de_prev_q     <= de_prev_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcount_q      <= hcount_d;
            hact_q        <= hact_d;
            vlines_q      <= vlines_d;
            vact_q        <= vact_d;
            stg_htotal_q  <= stg_htotal_d;
            stg_hactive_q <= stg_hactive_d;
            line_seen_q   <= line_seen_d;
            frame_seen_q  <= frame_seen_d;
            have_prev_q   <= have_prev_d;
            bad_q         <= bad_d;
            valid_q       <= valid_d;
            prev_timing_q <= prev_timing_d;
            out_timing_q  <= out_timing_d;
        end
    end

    assign o_r            = pix_r_q;
    assign o_g            = pix_g_q;
    assign o_b            = pix_b_q;
    assign o_de           = de_q;
    assign o_hsync        = hsync_q;
    assign o_vsync        = vsync_q;
    assign o_err_count    = err_q;
    assign o_timing_valid = valid_q;
    assign o_htotal       = out_timing_q.htotal;
    assign o_hactive      = out_timing_q.hactive;
    assign o_vtotal       = out_timing_q.vtotal;
    assign o_vactive      = out_timing_q.vactive;

endmodule

// File: tb/tb_hdmi_tmds_decoder.sv
// Bench: a reference TMDS encoder drives both decoders; expected pixels, syncs,
// error counts and frame timing come from a per-cycle model of the protocol.
module tb_hdmi_tmds_decoder;

    localparam int H   = 40;
    localparam int HA  = 32;
    localparam int HS0 = HA + 2;
    localparam int HS1 = HA + 6;
    localparam int V   = 26;
    localparam int VA  = 20;
    localparam int VS0 = VA + 2;
    localparam int VS1 = VA + 4;
    localparam logic [9:0] IDLE = 10'h354;

    logic       clk;
    logic       rst_n;
    logic [9:0] i_r, i_g, i_b;

    logic [7:0]  o_r, o_g, o_b;
    logic        o_de, o_hsync, o_vsync, o_timing_valid;
    logic [15:0] o_htotal, o_hactive, o_vtotal, o_vactive, o_err_count;

    // Narrow instance: its measurement counters overflow in vertical blanking
    // and its error counter saturates quickly.
    logic [7:0] s_r, s_g, s_b;
    logic       s_de, s_hsync, s_vsync, s_valid;
    logic [7:0] s_htotal, s_hactive, s_vtotal, s_vactive;
    logic [2:0] s_err;

    hdmi_tmds_decoder u_dut (
        .i_pix_clk(clk), .i_reset_n(rst_n), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_htotal(o_htotal), .o_hactive(o_hactive), .o_vtotal(o_vtotal), .o_vactive(o_vactive),
        .o_timing_valid(o_timing_valid), .o_err_count(o_err_count)
    );

    hdmi_tmds_decoder #(.LGDIM(8), .LGERR(3)) u_dut_sat (
        .i_pix_clk(clk), .i_reset_n(rst_n), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_r(s_r), .o_g(s_g), .o_b(s_b), .o_de(s_de), .o_hsync(s_hsync), .o_vsync(s_vsync),
        .o_htotal(s_htotal), .o_hactive(s_hactive), .o_vtotal(s_vtotal), .o_vactive(s_vactive),
        .o_timing_valid(s_valid), .o_err_count(s_err)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        known;
        logic [23:0] rgb;
        logic [15:0] err_main;
        logic [2:0]  err_small;
    } exp_t;

    int   checks;
    int   failures;
    bit   stream_en;
    int   err_cnt;
    logic exp_hs, exp_vs;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic int tok_c(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    // Reference transmitter encoder; inv selects the DC-balance inversion branch.
    function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
        logic [8:0] qm;
        int ones;
        ones  = $countones(d);
        qm[0] = d[0];
        if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    endfunction

    // One pixel clock: check the word driven two clocks earlier, then drive the next.
    task automatic tick(input logic [9:0] wr, input logic [9:0] wg, input logic [9:0] wb,
                        input logic [23:0] bytes);
        exp_t e;
        exp_t o;
        int   cr, cg, cb;
        logic agree;
        @(negedge clk);
        if (exp_q.size() == 2) begin
            o = exp_q.pop_front();
            if (stream_en) begin
                check("stream",
                      {o_de, o_hsync, o_vsync, o.known ? {o_r, o_g, o_b} : 24'h0, o_err_count, s_err},
                      {o.de, o.hs, o.vs, o.known ? o.rgb : 24'h0, o.err_main, o.err_small});
            end
        end
        i_r = wr;
        i_g = wg;
        i_b = wb;
        cr = tok_c(wr);
        cg = tok_c(wg);
        cb = tok_c(wb);
        agree = ((cr >= 0) == (cb >= 0)) && ((cg >= 0) == (cb >= 0));
        if (!agree) err_cnt++;
        if (cb >= 0) begin
            exp_hs = cb[0];
            exp_vs = cb[1];
        end
        e.de        = (cb < 0);
        e.hs        = exp_hs;
        e.vs        = exp_vs;
        e.known     = agree;
        e.rgb       = (cb < 0) ? bytes : 24'h0;
        e.err_main  = (err_cnt > 65535) ? 16'hFFFF : 16'(err_cnt);
        e.err_small = (err_cnt > 7) ? 3'd7 : 3'(err_cnt);
        exp_q.push_back(e);
    endtask

    task automatic tick_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [2:0] inv);
        tick(enc(r, inv[2]), enc(g, inv[1]), enc(b, inv[0]), {r, g, b});
    endtask

    task automatic tick_ctl(input logic [1:0] c);
        tick(tok(2'($urandom)), tok(2'($urandom)), tok(c), 24'h0);
    endtask

    task automatic frame_tick(input int l, input int x);
        logic [1:0] c;
        c = {(l >= VS0 && l < VS1), (x >= HS0 && x < HS1)};
        if (l < VA && x < HA) tick_pix(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
        else tick_ctl(c);
    endtask

    task automatic send_frame(input int w);
        for (int l = 0; l < V; l++)
            for (int x = 0; x < w; x++) frame_tick(l, x);
    endtask

    // Frame n (counted from reset) ends; w/w_prev are the widths of frames n and n-1.
    task automatic check_frame(input int n, input int w, input int w_prev);
        logic [63:0] q_exp;
        logic        v_exp;
        q_exp = (n >= 2) ? {16'(w), 16'(HA), 16'(V), 16'(VA)} : 64'h0;
        v_exp = (n >= 3) && (w == w_prev);
        check($sformatf("frame%0d_timing", n), {o_htotal, o_hactive, o_vtotal, o_vactive}, q_exp);
        check($sformatf("frame%0d_valid", n), o_timing_valid, v_exp);
        check($sformatf("frame%0d_sat_valid", n), s_valid, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        i_r = IDLE;
        i_g = IDLE;
        i_b = IDLE;
        #1;
        check({tag, "_pix"}, {o_r, o_g, o_b, o_de, o_hsync, o_vsync, o_err_count, s_err}, 0);
        check({tag, "_meas"}, {o_htotal, o_hactive, o_vtotal, o_vactive, o_timing_valid, s_valid}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_hs  = 1'b0;
        exp_vs  = 1'b0;
        err_cnt = 0;
    endtask

    initial begin
        int   sel;
        int   widths[$];
        logic [15:0] err_base;
        checks    = 0;
        failures  = 0;
        stream_en = 1'b1;
        rst_n     = 1'b1;
        i_r = IDLE;
        i_g = IDLE;
        i_b = IDLE;
        exp_hs  = 1'b0;
        exp_vs  = 1'b0;
        err_cnt = 0;
        #2;
        do_reset("reset");

        // Blue C=01 token with red/green C=00 tokens: hsync only, no error.
        err_base = 16'(err_cnt);
        tick(10'h354, 10'h354, 10'h0AB, 24'h0);
        tick(IDLE, IDLE, 10'h0AB, 24'h0);
        tick(IDLE, IDLE, 10'h0AB, 24'h0);
        check("ctl_token", {o_de, o_hsync, o_vsync, o_err_count}, {3'b010, err_base});

        // Every byte, both inversion branches, distinct per channel.
        for (int v = 0; v < 256; v++)
            for (int inv = 0; inv < 2; inv++)
                tick_pix(8'(v), 8'(255 - v), 8'(v * 7), {inv[0], ~inv[0], inv[0]});

        // Mixed data, control and channel-disagreement traffic.
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) tick_pix(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
            else if (sel < 9) tick_ctl(2'($urandom));
            else tick(enc(8'($urandom), 1'b0), tok(2'($urandom)), enc(8'($urandom), 1'b1),
                      24'h0);
        end

        // Error counter: five disagreeing clocks, twice; narrow counter saturates.
        @(negedge clk);
        do_reset("reset_err");
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 5; k++)
                tick(enc(8'($urandom), 1'b0), tok(2'($urandom)), enc(8'($urandom), 1'b0), 24'h0);
            tick(IDLE, IDLE, IDLE, 24'h0);
            tick(IDLE, IDLE, IDLE, 24'h0);
            check($sformatf("err_main_%0d", round), o_err_count, (round == 0) ? 16'd5 : 16'd10);
            check($sformatf("err_sat_%0d", round), s_err, (round == 0) ? 3'd5 : 3'd7);
        end

        // Frame timing: three stable frames, then a wider line length.
        stream_en = 1'b0;
        @(negedge clk);
        do_reset("reset_frames");
        widths = '{0, H, H, H, H + 1, H + 1, H + 1};
        for (int n = 1; n <= 6; n++) begin
            send_frame(widths[n]);
            check_frame(n, widths[n], widths[n-1]);
        end

        // Reset in the middle of a line, then measurements start over.
        for (int l = 0; l < 10; l++)
            for (int x = 0; x < H; x++) frame_tick(l, x);
        for (int x = 0; x < 15; x++) frame_tick(10, x);
        #3;
        do_reset("reset_midframe");
        for (int n = 1; n <= 3; n++) begin
            send_frame(H);
            check_frame(n, H, H);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
